// File: rtl/fifo_rx_apb.sv
// fifo_rx_apb: deserialises the CDR bit stream into WIDTH-bit words, buffers
// them in a DEPTH-entry circular FIFO and exposes DATA/STATUS/CTRL/THRESH
// registers on a zero-wait-state APB slave, with a level/overflow interrupt.
module fifo_rx_apb #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        bit_valid,
  input  logic        bit_in,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [7:0]  paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr,
  output logic        irq,
  output logic        mem_state
);

  localparam int PTR_WIDTH = $clog2(DEPTH);
  localparam int CNT_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [7:0] ADDR_DATA   = 8'h00;
  localparam logic [7:0] ADDR_STATUS = 8'h04;
  localparam logic [7:0] ADDR_CTRL   = 8'h08;
  localparam logic [7:0] ADDR_THRESH = 8'h0C;

  localparam logic [PTR_WIDTH:0] LEVEL_FULL   = (PTR_WIDTH + 1)'(DEPTH);
  localparam logic [PTR_WIDTH:0] THRESH_RESET = (PTR_WIDTH + 1)'(DEPTH / 2);

  logic [PTR_WIDTH:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0] bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic               overflow_q, overflow_d;
  logic               enable_q, enable_d;
  logic               msb_first_q, msb_first_d;
  logic               irq_en_q, irq_en_d;
  logic [PTR_WIDTH:0] thresh_q, thresh_d;
  logic [WIDTH-1:0]   mem [DEPTH];

  logic               access, wr_acc, rd_acc;
  logic               sel_data, sel_status, sel_ctrl, sel_thresh, mapped;
  logic [PTR_WIDTH:0] level;
  logic               empty, full, thresh_hit;
  logic               flush, take, last_bit, push_req, push, pop;
  logic [WIDTH:0]     ext_msb, ext_lsb;
  logic [WIDTH-1:0]   word_next;
  logic [31:0]        status_word;
  logic               unused_pwdata;

  // Only a handful of pwdata bits are meaningful; fold the rest away.
  assign unused_pwdata = ^pwdata;

  assign access     = psel & penable;
  assign wr_acc     = access & pwrite;
  assign rd_acc     = access & ~pwrite;
  assign sel_data   = (paddr == ADDR_DATA);
  assign sel_status = (paddr == ADDR_STATUS);
  assign sel_ctrl   = (paddr == ADDR_CTRL);
  assign sel_thresh = (paddr == ADDR_THRESH);
  assign mapped     = sel_data | sel_status | sel_ctrl | sel_thresh;

  assign level      = wr_ptr_q - rd_ptr_q;
  assign empty      = (level == '0);
  assign full       = (level == LEVEL_FULL);
  assign thresh_hit = (level >= thresh_q);

  assign pready     = 1'b1;
  assign mem_state  = ~empty;
  assign irq        = irq_en_q & (thresh_hit | overflow_q);

  // Control decode: bit intake, word completion, push/pop and flush.
  always_comb begin
    ext_msb   = {shift_q, bit_in};
    ext_lsb   = {bit_in, shift_q};
    word_next = msb_first_q ? ext_msb[WIDTH-1:0] : ext_lsb[WIDTH:1];
    flush     = wr_acc & sel_ctrl & pwdata[2];
    take      = enable_q & bit_valid;
    last_bit  = (bit_cnt_q == CNT_WIDTH'(WIDTH - 1));
    push_req  = take & last_bit & ~flush;
    push      = push_req & ~full;
    pop       = rd_acc & sel_data & ~empty & ~flush;
  end

  // Next-state logic for the deserializer, pointers and registers.
  // NOTE: every _d gets a default first so no path leaves it unassigned and infers a latch.
  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    overflow_d  = overflow_q;
    enable_d    = enable_q;
    msb_first_d = msb_first_q;
    irq_en_d    = irq_en_q;
    thresh_d    = thresh_q;

    if (!enable_q || flush) begin
      bit_cnt_d = '0;
      shift_d   = '0;
    end else if (take) begin
      if (last_bit) begin
        bit_cnt_d = '0;
        shift_d   = '0;
      end else begin
        bit_cnt_d = bit_cnt_q + CNT_WIDTH'(1);
        shift_d   = word_next;
      end
    end

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // A new overflow outranks a simultaneous write-1-to-clear.
    if (push_req && full)                         overflow_d = 1'b1;
    else if (wr_acc && sel_status && pwdata[2])   overflow_d = 1'b0;

    if (wr_acc && sel_ctrl) begin
      enable_d    = pwdata[0];
      msb_first_d = pwdata[1];
      irq_en_d    = pwdata[3];
    end
    if (wr_acc && sel_thresh) thresh_d = pwdata[PTR_WIDTH:0];
  end

  // State registers with asynchronous active-low reset.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      overflow_q  <= 1'b0;
      enable_q    <= 1'b0;
      msb_first_q <= 1'b0;
      irq_en_q    <= 1'b0;
      thresh_q    <= THRESH_RESET;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      overflow_q  <= overflow_d;
      enable_q    <= enable_d;
      msb_first_q <= msb_first_d;
      irq_en_q    <= irq_en_d;
      thresh_q    <= thresh_d;
    end
  end

  // FIFO storage write port.
  // NOTE: the storage array is deliberately not reset; the pointers alone define valid contents.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q[PTR_WIDTH-1:0]] <= word_next;
  end

  // APB read mux and error response, driven only during the access phase.
  always_comb begin
    status_word = '0;
    status_word[0] = empty;
    status_word[1] = full;
    status_word[2] = overflow_q;
    status_word[3] = thresh_hit;
    status_word[PTR_WIDTH+8:8] = level;

    pslverr = access & (~mapped | (sel_data & (pwrite | empty)));
    prdata  = '0;
    if (rd_acc && !pslverr) begin
      if (sel_data)        prdata = 32'(mem[rd_ptr_q[PTR_WIDTH-1:0]]);
      else if (sel_status) prdata = status_word;
      else if (sel_ctrl)   prdata = {28'd0, irq_en_q, 1'b0, msb_first_q, enable_q};
      else if (sel_thresh) prdata = 32'(thresh_q);
    end
  end

endmodule

// File: tb/tb_fifo_rx_apb.sv
// tb_fifo_rx_apb: directed bench for fifo_rx_apb (WIDTH=8, DEPTH=64) with
// hand-computed expected register values.
module tb_fifo_rx_apb;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        bit_valid, bit_in;
  logic        psel, penable, pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready, pslverr, irq, mem_state;

  int n_total = 0;
  int n_bad   = 0;

  fifo_rx_apb #(.WIDTH(8), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bit_valid (bit_valid),
    .bit_in    (bit_in),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .prdata    (prdata),
    .pready    (pready),
    .pslverr   (pslverr),
    .irq       (irq),
    .mem_state (mem_state)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic apb_write(input logic [7:0] addr, input logic [31:0] data);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = addr; pwdata = data;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] addr, output logic [31:0] data, output logic err);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = addr;
    @(negedge clk);
    penable = 1'b1;
    #1;
    data = prdata;
    err  = pslverr;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    bit_valid = 1'b1; bit_in = b;
    @(negedge clk);
    bit_valid = 1'b0;
  endtask

  // Sends bits MSB first; with msb_first=1 the stored word equals w.
  task automatic send_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) send_bit(w[i]);
  endtask

  logic [31:0] rd;
  logic        err;
  logic [7:0]  pat_a5;
  logic [7:0]  pat_03;

  initial begin
    reset_n = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Reset state
    check("rst_prdata", prdata, 32'h0);
    check("rst_pslverr", {31'd0, pslverr}, 32'h0);
    check("rst_irq", {31'd0, irq}, 32'h0);
    check("rst_mem_state", {31'd0, mem_state}, 32'h0);
    check("rst_pready", {31'd0, pready}, 32'h1);
    apb_read(8'h08, rd, err); check("rst_ctrl", rd, 32'h0);
    apb_read(8'h0C, rd, err); check("rst_thresh", rd, 32'd32);
    apb_read(8'h04, rd, err); check("rst_status", rd, 32'h1);

    // Basic receive, MSB first: 1,0,1,0,0,1,0,1 -> 0xA5
    apb_write(8'h08, 32'h3);
    pat_a5 = 8'b1010_0101;
    for (int i = 7; i >= 0; i--) send_bit(pat_a5[i]);
    apb_read(8'h04, rd, err); check("msb_status", rd, 32'h100);
    check("msb_mem_state", {31'd0, mem_state}, 32'h1);
    apb_read(8'h00, rd, err); check("msb_data", rd, 32'hA5);
    check("msb_data_err", {31'd0, err}, 32'h0);
    apb_read(8'h04, rd, err); check("msb_status_empty", rd, 32'h1);

    // LSB first: bits 1,1,0,0,0,0,0,0 -> 0x03
    apb_write(8'h08, 32'h1);
    pat_03 = 8'b1100_0000;
    for (int i = 7; i >= 0; i--) send_bit(pat_03[i]);
    apb_read(8'h00, rd, err); check("lsb_data", rd, 32'h03);

    // Fill and overflow: words 0..DEPTH, the last one is dropped
    apb_write(8'h08, 32'h3);
    for (int i = 0; i <= DEPTH; i++) send_word(8'(i));
    // full | overflow | thresh_hit | level 64
    apb_read(8'h04, rd, err); check("full_status", rd, 32'h0000_400E);
    for (int i = 0; i < DEPTH; i++) begin
      apb_read(8'h00, rd, err);
      check($sformatf("fill_data_%0d", i), rd, 32'(i));
    end
    apb_read(8'h04, rd, err); check("drained_status", rd, 32'h5);
    apb_write(8'h04, 32'h4);
    apb_read(8'h04, rd, err); check("ovf_cleared", rd, 32'h1);

    // Empty read and bad address
    apb_read(8'h00, rd, err);
    check("empty_rd_err", {31'd0, err}, 32'h1);
    check("empty_rd_data", rd, 32'h0);
    apb_read(8'h04, rd, err); check("empty_rd_level", rd, 32'h1);
    apb_read(8'h20, rd, err); check("bad_addr_err", {31'd0, err}, 32'h1);

    // Threshold and irq
    apb_write(8'h0C, 32'd4);
    apb_write(8'h08, 32'hB);
    for (int i = 0; i < 3; i++) send_word(8'h10 + 8'(i));
    check("irq_below", {31'd0, irq}, 32'h0);
    send_word(8'h13);
    check("irq_at_thresh", {31'd0, irq}, 32'h1);
    apb_read(8'h00, rd, err); check("irq_pop_data", rd, 32'h10);
    check("irq_after_pop", {31'd0, irq}, 32'h0);
    for (int i = 1; i < 4; i++) begin
      apb_read(8'h00, rd, err);
      check($sformatf("irq_drain_%0d", i), rd, 32'h10 + 32'(i));
    end
    apb_write(8'h0C, 32'd0);
    apb_read(8'h04, rd, err); check("thresh0_status", rd, 32'h9);
    check("thresh0_irq", {31'd0, irq}, 32'h1);
    apb_write(8'h0C, 32'd100);
    apb_write(8'h08, 32'h3);

    // Partial word discarded by disable
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    apb_write(8'h08, 32'h0);
    apb_write(8'h08, 32'h3);
    send_word(8'h3C);
    apb_read(8'h04, rd, err); check("disable_level", rd, 32'h100);
    apb_read(8'h00, rd, err); check("disable_data", rd, 32'h3C);

    // Flush empties FIFO and discards a partial word; flush reads back 0
    for (int i = 0; i < 3; i++) send_word(8'hC0 + 8'(i));
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    apb_write(8'h08, 32'h7);
    apb_read(8'h04, rd, err); check("flush_status", rd, 32'h1);
    apb_read(8'h08, rd, err); check("flush_ctrl", rd, 32'h3);
    send_word(8'h5A);
    apb_read(8'h04, rd, err); check("flush_one_word", rd, 32'h100);
    apb_read(8'h00, rd, err); check("flush_data", rd, 32'h5A);

    // Pointer wrap across 3*DEPTH push/pop pairs, with one word kept in flight
    send_word(8'hEE);
    for (int i = 0; i < 3 * DEPTH; i++) begin
      send_word(8'((i * 37 + 11) & 8'hFF));
      apb_read(8'h00, rd, err);
      if (i == 0) check("wrap_first", rd, 32'hEE);
      else        check($sformatf("wrap_%0d", i), rd, 32'(((i - 1) * 37 + 11) & 8'hFF));
    end
    apb_read(8'h00, rd, err); check("wrap_last", rd, 32'(((3 * DEPTH - 1) * 37 + 11) & 8'hFF));
    apb_read(8'h04, rd, err); check("wrap_status", rd, 32'h1);

    // Reset mid-word returns everything to defaults
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    @(negedge clk); reset_n = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    apb_read(8'h08, rd, err); check("rst2_ctrl", rd, 32'h0);
    apb_read(8'h04, rd, err); check("rst2_status", rd, 32'h1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
